// File: rtl/imem_stream_loader_if.sv
// Stream input and instruction-memory write port of the boot loader.
// The master side feeds the word stream and observes the imem write port.
interface imem_stream_loader_if #(
    parameter int AW = 10
);
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    modport master (
        output s_valid, s_data,
        input  s_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_stream_loader.sv
// Boot-time loader: takes a framed word stream (header, payload, checksum),
// writes the payload into imem and releases the core only after a good checksum.
module imem_stream_loader #(
    parameter int          IMEM_DEPTH  = 1024,
    parameter int          HOLD_CYCLES = 4,
    parameter logic [15:0] MAGIC       = 16'hC0DE,
    localparam int         AW          = $clog2(IMEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    imem_stream_loader_if.slave  bus,
    output logic                 cpu_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [AW:0]          words_loaded
);
    localparam int          HCW     = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_L = HCW'(HOLD_CYCLES);
    localparam logic [16:0] DEPTH_L = 17'(IMEM_DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR, ST_LOAD, ST_CHK, ST_RELEASE, ST_DONE, ST_ERROR
    } state_t;

    state_t          state_r, state_s;
    logic            s_ready_r, imem_we_r, cpu_rst_n_r, busy_r, done_r, err_r;
    logic [AW-1:0]   imem_addr_r;
    logic [31:0]     imem_wdata_r, checksum_r;
    logic [1:0]      err_code_r, err_code_s;
    logic [AW:0]     words_loaded_r, len_r;
    logic [HCW-1:0]  hold_cnt_r;
    logic            xfer_s, bad_magic_s, bad_len_s, last_word_s;
    logic            start_acc_s, hdr_ok_s, load_xfer_s;

    // s_ready is registered from the next state, so it always matches state_r
    assign xfer_s      = bus.s_valid && s_ready_r;
    assign bad_magic_s = (bus.s_data[31:16] != MAGIC);
    assign bad_len_s   = (bus.s_data[15:0] == 16'd0) || ({1'b0, bus.s_data[15:0]} > DEPTH_L);
    assign last_word_s = ((words_loaded_r + ONE_W) == len_r);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state and error classification
    always_comb begin
        state_s     = state_r;
        err_code_s  = err_code_r;
        start_acc_s = 1'b0;
        hdr_ok_s    = 1'b0;
        load_xfer_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_s     = ST_HDR;
                    err_code_s  = 2'd0;
                    start_acc_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_HDR: begin
                if (xfer_s) begin
                    if (bad_magic_s) begin
                        state_s    = ST_ERROR;
                        err_code_s = 2'd1;
                    end else if (bad_len_s) begin
                        state_s    = ST_ERROR;
                        err_code_s = 2'd2;
                    end else begin
                        state_s  = ST_LOAD;
                        hdr_ok_s = 1'b1;
                    end
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_LOAD: begin
                load_xfer_s = xfer_s;
                if (xfer_s && last_word_s) begin
                    state_s = ST_CHK;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_CHK: begin
                if (xfer_s) begin
                    if (bus.s_data == checksum_r) begin
                        state_s = ST_RELEASE;
                    end else begin
                        state_s    = ST_ERROR;
                        err_code_s = 2'd3;
                    end
                end else begin
                    state_s = ST_CHK;
                end
            end
            ST_RELEASE: begin
                if (hold_cnt_r == HOLD_L) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RELEASE;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                err_code_s = 2'd0;
            end
        endcase
    end

    // Registered status outputs, decoded from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready_r   <= 1'b0;
            cpu_rst_n_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= 2'd0;
        end else begin
            s_ready_r   <= (state_s == ST_HDR) || (state_s == ST_LOAD) || (state_s == ST_CHK);
            busy_r      <= (state_s == ST_HDR) || (state_s == ST_LOAD) ||
                           (state_s == ST_CHK) || (state_s == ST_RELEASE);
            cpu_rst_n_r <= (state_s == ST_DONE);
            done_r      <= (state_s == ST_DONE);
            err_r       <= (state_s == ST_ERROR);
            err_code_r  <= err_code_s;
        end
    end

    // Payload write port, running checksum, word count and release hold counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we_r      <= 1'b0;
            imem_addr_r    <= '0;
            imem_wdata_r   <= 32'd0;
            checksum_r     <= 32'd0;
            words_loaded_r <= '0;
            len_r          <= '0;
            hold_cnt_r     <= '0;
        end else begin
            imem_we_r <= load_xfer_s;
            if (start_acc_s) begin
                words_loaded_r <= '0;
                checksum_r     <= 32'd0;
            end else if (load_xfer_s) begin
                imem_addr_r    <= words_loaded_r[AW-1:0];
                imem_wdata_r   <= bus.s_data;
                checksum_r     <= checksum_r + bus.s_data;
                words_loaded_r <= words_loaded_r + ONE_W;
            end
            // length already range-checked, so it fits in AW+1 bits
            if (hdr_ok_s) begin
                len_r <= bus.s_data[AW:0];
            end
            if (state_r == ST_RELEASE) begin
                hold_cnt_r <= hold_cnt_r + HCW'(1);
            end else begin
                hold_cnt_r <= '0;
            end
        end
    end

    assign bus.s_ready     = s_ready_r;
    assign bus.imem_we     = imem_we_r;
    assign bus.imem_addr   = imem_addr_r;
    assign bus.imem_wdata  = imem_wdata_r;
    assign cpu_rst_n       = cpu_rst_n_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign err             = err_r;
    assign err_code        = err_code_r;
    assign words_loaded    = words_loaded_r;
endmodule
